gb_async_mem: RTL and testbench

Parameterised single-port memory with a synchronous write, a combinational (asynchronous) read, and a power-up scrub engine. It serves as the work RAM and video RAM behind the `gameboy` core's CPU bus and VRAM bus in simulation and FPGA builds. The memory aliases high address bits, so echo regions mirror the base array. It holds reads and writes off while the contents are being zeroed after reset.

---
 rtl/gb_async_mem_if.sv | 29 ++
 rtl/gb_async_mem.sv | 100 ++++++++++
 tb/tb_gb_async_mem.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/gb_async_mem_if.sv
// gb_async_mem_if
// Bus bundle between a memory master (CPU or video fetch) and gb_async_mem.
//   addr       : shared read/write address (asz bits)
//   wr_data    : write data (dw bits)
//   wr_cs      : write strobe, sampled on every rising clock edge
//   rd_cs      : read select
//   rd_data    : combinational read data from the memory
//   clear_busy : memory is in reset or still zeroing its contents
interface gb_async_mem_if #(
   parameter int asz = 16,
   parameter int dw  = 8
);
   logic [asz-1:0] addr;
   logic [dw-1:0]  wr_data;
   logic           wr_cs;
   logic           rd_cs;
   logic [dw-1:0]  rd_data;
   logic           clear_busy;

   modport master (
      output addr, wr_data, wr_cs, rd_cs,
      input  rd_data, clear_busy
   );

   modport slave (
      input  addr, wr_data, wr_cs, rd_cs,
      output rd_data, clear_busy
   );
endinterface

// File: rtl/gb_async_mem.sv
// gb_async_mem
// Single-port RAM with synchronous write, combinational read and a
// power-up scrub engine that zeroes every word after reset.
// High address bits are ignored, so echo regions mirror the base array.
// Ports:
//   wr_clk : the single clock; writes and scrub advance on its rising edge
//   reset  : asynchronous, active-high; restarts the scrub from index 0
//   bus    : gb_async_mem_if slave (addr, wr_data, wr_cs, rd_cs,
//            rd_data, clear_busy)
module gb_async_mem #(
   parameter int asz   = 16,
   parameter int depth = 8192,
   parameter int dw    = 8
) (
   input  logic           wr_clk,
   input  logic           reset,
   gb_async_mem_if.slave  bus
);
   localparam int aw = $clog2(depth);
   // Counter carries one extra bit so the terminal compare never wraps.
   localparam logic [aw:0] last_idx = (aw+1)'(depth - 1);

   typedef enum logic {
      IDLE,
      SCRUB
   } state_t;

   state_t         state_reg, state_next;
   logic [aw:0]    cnt_reg, cnt_next;

   logic [dw-1:0]  mem [depth];

   logic [aw-1:0]  idx;
   logic           busy;
   logic           mem_we;
   logic [aw-1:0]  mem_waddr;
   logic [dw-1:0]  mem_wdata;
   logic [dw-1:0]  rd_value;

   // Upper address bits alias onto the base array on purpose.
   logic           unused_addr_bits;
   assign unused_addr_bits = ^bus.addr;

   assign idx  = bus.addr[aw-1:0];
   // Busy covers the reset pulse itself as well as the scrub pass.
   assign busy = reset | (state_reg == SCRUB);

   always_ff @(posedge wr_clk or posedge reset) begin
      if (reset) begin
         state_reg <= SCRUB;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // The scrub owns the write port while active; bus writes are dropped.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      mem_we     = 1'b0;
      mem_waddr  = idx;
      mem_wdata  = bus.wr_data;
      case (state_reg)
         SCRUB: begin
            mem_we    = 1'b1;
            mem_waddr = cnt_reg[aw-1:0];
            mem_wdata = '0;
            cnt_next  = cnt_reg + 1'b1;
            if (cnt_reg == last_idx) begin
               state_next = IDLE;
            end
         end
         default: begin
            mem_we = bus.wr_cs & ~busy;
         end
      endcase
   end

   // Contents are never touched by reset directly, only by the scrub.
   always_ff @(posedge wr_clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // Deselected reads float high (open bus); reads during scrub return zero.
   always_comb begin
      rd_value = mem[idx];
      if (!bus.rd_cs) begin
         rd_value = '1;
      end else if (busy) begin
         rd_value = '0;
      end
   end

   assign bus.rd_data    = rd_value;
   assign bus.clear_busy = busy;
endmodule

// File: tb/tb_gb_async_mem.sv
module tb_gb_async_mem;
   localparam int ASZ   = 16;
   localparam int DEPTH = 8192;
   localparam int DW    = 8;
   localparam int SCRUB_BOUND = 20000;

   logic clk;
   logic reset;

   gb_async_mem_if #(.asz(ASZ), .dw(DW)) bus ();

   gb_async_mem #(.asz(ASZ), .depth(DEPTH), .dw(DW)) dut (
      .wr_clk (clk),
      .reset  (reset),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: plain array plus "edges until the memory is clean".
   logic [7:0] model_mem [DEPTH];
   int         busy_left;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic        wr;
      logic        rd;
      logic [7:0]  exp_pre;
      logic [7:0]  exp_post;
   } vec_t;

   vec_t vecs[12];

   function automatic bit model_busy();
      return (reset == 1'b1) || (busy_left != 0);
   endfunction

   function automatic logic [7:0] model_read(logic [15:0] a, logic rd);
      if (!rd) return 8'hFF;
      if (model_busy()) return 8'h00;
      return model_mem[int'(a) % DEPTH];
   endfunction

   task automatic check8(string name, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(logic [15:0] a, logic [7:0] d, logic wr, logic rd);
      bus.addr    = a;
      bus.wr_data = d;
      bus.wr_cs   = wr;
      bus.rd_cs   = rd;
      #1;
   endtask

   // One rising edge; the model applies the same edge's effects.
   task automatic step();
      if (bus.wr_cs && !model_busy())
         model_mem[int'(bus.addr) % DEPTH] = bus.wr_data;
      if (!reset && busy_left > 0) begin
         busy_left--;
         if (busy_left == 0)
            for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_reset(logic v);
      reset = v;
      if (v) busy_left = DEPTH;
      #1;
   endtask

   // Runs edges until clear_busy falls; optionally tries a write to addr 5
   // at edge 100 (long after the scrub passed index 5) that must be dropped.
   task automatic wait_scrub(output int edges, input bit try_drop);
      edges = 0;
      while (bus.clear_busy === 1'b1 && edges < SCRUB_BOUND) begin
         if (try_drop && edges == 99) drive(16'h0005, 8'h33, 1'b1, 1'b1);
         else if (try_drop && edges == 100) drive(16'h0005, 8'h33, 1'b0, 1'b1);
         step();
         edges++;
      end
      bus.wr_cs = 1'b0;
      #1;
   endtask

   task automatic random_phase(int n, int base);
      logic [15:0] a;
      logic [7:0]  d;
      logic        wr, rd;
      logic [7:0]  exp;
      for (int t = 0; t < n; t++) begin
         if ($urandom_range(0, 3) == 0) a = 16'($urandom);
         else a = {3'($urandom), 8'h00, 5'($urandom_range(0, 31))};
         d  = 8'($urandom);
         wr = 1'($urandom_range(0, 1));
         rd = ($urandom_range(0, 4) != 0);
         drive(a, d, wr, rd);
         exp = model_read(a, rd);
         check8("rand_pre", bus.rd_data, exp);
         step();
         exp = model_read(a, rd);
         check8("rand_post", bus.rd_data, exp);
         $display("txn %0d addr=%h wr=%b rd=%b wdata=%h rd_data=%h",
                  base + t, a, wr, rd, d, bus.rd_data);
      end
   endtask

   initial begin
      int edges;
      int bad;

      vecs[0]  = '{16'hC010, 8'h5A, 1'b1, 1'b1, 8'h00, 8'h5A};
      vecs[1]  = '{16'hE010, 8'h00, 1'b0, 1'b1, 8'h5A, 8'h5A};
      vecs[2]  = '{16'hC010, 8'h00, 1'b0, 1'b0, 8'hFF, 8'hFF};
      vecs[3]  = '{16'h0007, 8'h11, 1'b1, 1'b1, 8'h00, 8'h11};
      vecs[4]  = '{16'h0007, 8'h22, 1'b1, 1'b1, 8'h11, 8'h22};
      vecs[5]  = '{16'h1FFF, 8'hFF, 1'b1, 1'b1, 8'h00, 8'hFF};
      vecs[6]  = '{16'h0000, 8'h01, 1'b1, 1'b1, 8'h00, 8'h01};
      vecs[7]  = '{16'h1FFF, 8'h00, 1'b0, 1'b1, 8'hFF, 8'hFF};
      vecs[8]  = '{16'h0000, 8'h00, 1'b0, 1'b1, 8'h01, 8'h01};
      vecs[9]  = '{16'hE000, 8'h00, 1'b0, 1'b1, 8'h01, 8'h01};
      vecs[10] = '{16'h2000, 8'h77, 1'b1, 1'b0, 8'hFF, 8'hFF};
      vecs[11] = '{16'h0000, 8'h00, 1'b0, 1'b1, 8'h77, 8'h77};

      busy_left = DEPTH;
      reset = 1'b1;
      drive(16'h0000, 8'h00, 1'b0, 1'b0);

      // Reset state and a write attempt while reset is held.
      step();
      step();
      check_int("reset_busy", int'(bus.clear_busy), 1);
      check8("reset_rd_off", bus.rd_data, 8'hFF);
      drive(16'hC000, 8'hAA, 1'b1, 1'b1);
      check8("reset_rd_on", bus.rd_data, 8'h00);
      step();
      drive(16'h0000, 8'h00, 1'b0, 1'b0);
      $display("txn reset held, clear_busy=%b", bus.clear_busy);

      // First scrub with a dropped write to addr 5 mid-way.
      set_reset(1'b0);
      wait_scrub(edges, 1'b1);
      $display("txn scrub1 edges=%0d", edges);
      check_int("scrub1_edges", edges, DEPTH);
      drive(16'h0005, 8'h00, 1'b0, 1'b1);
      check8("dropped_wr_addr5", bus.rd_data, 8'h00);

      // Write 0xAA, then reset and confirm the scrub clears it.
      drive(16'hC000, 8'hAA, 1'b1, 1'b1);
      step();
      drive(16'hC000, 8'h00, 1'b0, 1'b1);
      check8("pre_reset_C000", bus.rd_data, 8'hAA);
      set_reset(1'b1);
      check_int("async_busy", int'(bus.clear_busy), 1);
      check8("busy_rd_zero", bus.rd_data, 8'h00);
      step();
      set_reset(1'b0);
      wait_scrub(edges, 1'b0);
      $display("txn scrub2 edges=%0d", edges);
      check_int("scrub2_edges", edges, DEPTH);
      check8("scrubbed_C000", bus.rd_data, 8'h00);

      // Table-driven vectors: aliasing, open bus, read-during-write, last index.
      for (int v = 0; v < 12; v++) begin
         drive(vecs[v].addr, vecs[v].wdata, vecs[v].wr, vecs[v].rd);
         check8($sformatf("vec%0d_pre", v), bus.rd_data, vecs[v].exp_pre);
         step();
         check8($sformatf("vec%0d_post", v), bus.rd_data, vecs[v].exp_post);
         $display("txn vec%0d addr=%h wr=%b rd=%b wdata=%h rd_data=%h",
                  v, vecs[v].addr, vecs[v].wr, vecs[v].rd, vecs[v].wdata, bus.rd_data);
      end

      // Randomised traffic against the model.
      random_phase(400, 0);
      for (int i = 0; i < 32; i++) model_mem[i] = model_mem[i];

      // Reset mid-scrub at edge 3000: a full new scrub must follow.
      bus.wr_cs = 1'b0;
      set_reset(1'b1);
      step();
      set_reset(1'b0);
      for (int e = 0; e < 3000; e++) step();
      check_int("mid_scrub_busy", int'(bus.clear_busy), 1);
      set_reset(1'b1);
      step();
      set_reset(1'b0);
      wait_scrub(edges, 1'b0);
      $display("txn mid-scrub restart edges=%0d", edges);
      check_int("restart_edges", edges, DEPTH);

      bad = 0;
      for (int a = 0; a < DEPTH; a++) begin
         drive(16'(a), 8'h00, 1'b0, 1'b1);
         if (bus.rd_data !== 8'h00) bad++;
      end
      check_int("all_zero_words", bad, 0);

      random_phase(100, 400);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
